if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the RV32I core. Owns the PC and

---
 rtl/riscv_pkg.sv | 14 +
 rtl/ifid_reg.sv | 49 ++++
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch FSM states, the canonical NOP bubble
// and the halt opcode decoded by the controller.
package riscv_pkg;

    localparam int          PC_W_DEF  = 9;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OPC_HALT  = 7'b0000000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. A clear loads a NOP bubble; the link address
// (pc + 4) is captured alongside the PC so decode sees it straight off a flop.
module ifid_reg
    import riscv_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PC_W-1:0]    pc_d,
    input  logic [INSTR_W-1:0] instr_d,
    output logic [PC_W-1:0]    pc_q,
    output logic [PC_W-1:0]    pc4_q,
    output logic [INSTR_W-1:0] instr_q,
    output logic               valid_q
);

    localparam logic [PC_W-1:0]    PC_FOUR   = PC_W'(4);
    localparam logic [INSTR_W-1:0] BUBBLE_IR = INSTR_W'(NOP_INSTR);

    // Bubble takes priority over load; the bubble PC is zero with its wrapped link value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            pc4_q   <= PC_FOUR;
            instr_q <= BUBBLE_IR;
            valid_q <= 1'b0;
        end else if (clr) begin
            pc_q    <= '0;
            pc4_q   <= PC_FOUR;
            instr_q <= BUBBLE_IR;
            valid_q <= 1'b0;
        end else if (en) begin
            pc_q    <= pc_d;
            pc4_q   <= pc_d + PC_FOUR;
            instr_q <= instr_d;
            valid_q <= 1'b1;
        end else begin
            pc_q    <= pc_q;
            pc4_q   <= pc4_q;
            instr_q <= instr_q;
            valid_q <= valid_q;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the RUN/HALTED fetch FSM, counts
// accepted instructions and feeds the IF/ID register.
module if_stage
    import riscv_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    input  logic               halt_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic [PC_W-1:0]    ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o,
    output logic               halted_o,
    output logic [31:0]        fetch_count_o
);

    localparam logic [PC_W-1:0] PC_FOUR  = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MK = ~PC_W'(3);
    localparam logic [31:0]     CNT_MAX  = 32'hFFFF_FFFF;

    fetch_state_e      state_r;
    logic [PC_W-1:0]   pc_r;
    logic [31:0]       count_r;
    logic              halted_r;
    logic              halt_q_s;
    logic              ifid_en_s;
    logic              ifid_clr_s;

    // A halt request only counts when decode holds a real instruction.
    assign halt_q_s = halt_i & ifid_valid_o;

    // IF/ID load/flush control following the RUN-state priority order.
    always_comb begin
        ifid_en_s  = 1'b0;
        ifid_clr_s = 1'b0;
        case (state_r)
            RUN: begin
                if (redirect_i) begin
                    ifid_clr_s = 1'b1;
                end else if (halt_q_s || stall_i) begin
                    ifid_en_s = 1'b0;
                end else begin
                    ifid_en_s = 1'b1;
                end
            end
            HALTED: begin
                ifid_en_s = 1'b0;
            end
            default: begin
                ifid_clr_s = 1'b1;
            end
        endcase
    end

    // Fetch FSM with PC, saturating counter and halted flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= RUN;
            pc_r     <= RESET_PC;
            count_r  <= 32'd0;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (redirect_i) begin
                        pc_r <= redirect_pc_i & ALIGN_MK;
                    end else if (halt_q_s) begin
                        state_r  <= HALTED;
                        halted_r <= 1'b1;
                    end else if (stall_i) begin
                        pc_r <= pc_r;
                    end else begin
                        pc_r <= pc_r + PC_FOUR;
                        if (count_r != CNT_MAX) begin
                            count_r <= count_r + 32'd1;
                        end else begin
                            count_r <= count_r;
                        end
                    end
                end
                HALTED: begin
                    state_r  <= HALTED;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= RUN;
                    pc_r     <= RESET_PC;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    ifid_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_ifid_reg (
        .clk     (clk),
        .rst_n   (reset_n),
        .en      (ifid_en_s),
        .clr     (ifid_clr_s),
        .pc_d    (pc_r),
        .instr_d (imem_rdata_i),
        .pc_q    (ifid_pc_o),
        .pc4_q   (ifid_pc4_o),
        .instr_q (ifid_instr_o),
        .valid_q (ifid_valid_o)
    );

    assign imem_addr_o   = pc_r;
    assign halted_o      = halted_r;
    assign fetch_count_o = count_r;

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a behavioural model of
// the fetch rules (PC arithmetic modulo 512, queue-free register model).
module tb_if_stage;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_i;
    logic [8:0]  redirect_pc_i;
    logic        halt_i;
    logic [8:0]  imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [8:0]  ifid_pc_o;
    logic [8:0]  ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;

    logic [31:0] imem [0:127];

    int checks_cnt;
    int errors_cnt;

    // reference state
    int          m_pc;
    int          m_ifid_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_halted;
    longint      m_count;

    if_stage #(.PC_W(9), .INSTR_W(32), .RESET_PC(9'd0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o),
        .fetch_count_o (fetch_count_o)
    );

    assign imem_rdata_i = imem[imem_addr_o[8:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%h expected=%h time=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("imem_addr", 32'(imem_addr_o), 32'(m_pc));
        check_eq("ifid_pc", 32'(ifid_pc_o), 32'(m_ifid_pc));
        check_eq("ifid_pc4", 32'(ifid_pc4_o), 32'((m_ifid_pc + 4) % 512));
        check_eq("ifid_instr", ifid_instr_o, m_instr);
        check_eq("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
        check_eq("halted", 32'(halted_o), 32'(m_halted));
        check_eq("fetch_count", fetch_count_o, m_count[31:0]);
    endtask

    task automatic model_reset();
        m_pc      = 0;
        m_ifid_pc = 0;
        m_instr   = 32'h0000_0013;
        m_valid   = 1'b0;
        m_halted  = 1'b0;
        m_count   = 0;
    endtask

    // One clock of the fetch rules, evaluated on the inputs present at the edge.
    task automatic model_step(input bit st, input bit rd, input int rpc, input bit hl);
        if (m_halted) return;
        if (rd) begin
            m_pc      = rpc - (rpc % 4);
            m_ifid_pc = 0;
            m_instr   = 32'h0000_0013;
            m_valid   = 1'b0;
        end else if (hl && m_valid) begin
            m_halted = 1'b1;
        end else if (!st) begin
            m_ifid_pc = m_pc;
            m_instr   = imem[m_pc / 4];
            m_valid   = 1'b1;
            m_pc      = (m_pc + 4) % 512;
            if (m_count < 64'hFFFF_FFFF) m_count++;
        end
    endtask

    task automatic cycle(input bit st, input bit rd, input int rpc, input bit hl);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = 9'(rpc);
        halt_i        = hl;
        @(posedge clk);
        model_step(st, rd, rpc, hl);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset_n       = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 9'd0;
        halt_i        = 1'b0;
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        reset_n       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 9'd0;
        halt_i        = 1'b0;
        for (int n = 0; n < 128; n++) imem[n] = 32'h0010_0093 + 32'(n);
        model_reset();
        #12;
        reset_n = 1'b1;

        // free run from reset, then a two-cycle stall at pc=8
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 0, 1'b0);
        check_eq("pc_before_stall", 32'(imem_addr_o), 32'd8);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        check_eq("stall_addr", 32'(imem_addr_o), 32'd8);
        check_eq("stall_count", fetch_count_o, 32'd2);
        cycle(1'b0, 1'b0, 0, 1'b0);
        check_eq("resume_pc", 32'(imem_addr_o), 32'd12);
        cycle(1'b0, 1'b0, 0, 1'b0);

        // redirect with misaligned target, then redirect beating a stall
        cycle(1'b0, 1'b1, 32'h43, 1'b0);
        check_eq("redir_pc", 32'(imem_addr_o), 32'h40);
        check_eq("redir_bubble", ifid_instr_o, 32'h0000_0013);
        cycle(1'b1, 1'b1, 32'h100, 1'b0);
        check_eq("redir_stall_pc", 32'(imem_addr_o), 32'h100);

        // halt ignored with redirect and with empty IF/ID; then PC wrap
        cycle(1'b0, 1'b1, 32'h1FC, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b1);
        check_eq("halt_invalid_ignored", 32'(halted_o), 32'd0);
        check_eq("wrap_pc", 32'(imem_addr_o), 32'd0);
        check_eq("wrap_pc4", 32'(ifid_pc4_o), 32'd0);

        // halt on an all-zero instruction, frozen through redirects, cleared by reset
        imem[48] = 32'h0000_0000;
        cycle(1'b0, 1'b1, 32'hC0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        check_eq("halt_instr", ifid_instr_o, 32'h0);
        cycle(1'b0, 1'b0, 0, 1'b1);
        check_eq("halted_set", 32'(halted_o), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'($urandom_range(1)), 1'b1, int'($urandom_range(511)), 1'b0);
        check_eq("halted_pc_frozen", 32'(imem_addr_o), 32'hC4);
        do_reset();
        check_eq("reset_halted", 32'(halted_o), 32'd0);
        imem[48] = 32'h0010_0093 + 32'd48;

        // randomized traffic with periodic resets
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < 128; n++)
                imem[n] = ($urandom_range(15) == 0) ? 32'h0 : $urandom;
            do_reset();
            for (int i = 0; i < 80; i++) begin
                cycle(1'($urandom_range(3) == 0), 1'($urandom_range(9) == 0),
                      int'($urandom_range(511)), 1'($urandom_range(15) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
